// File: rtl/divu_seq_if.sv
// Handshake and operand/result bundle between the pipeline and the sequential divider.
// The pipeline is the master (drives start/operands); the divider is the slave (drives status/result).
interface divu_seq_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [3:0]           Signal;
  logic [WIDTH-1:0]     dataA;
  logic [WIDTH-1:0]     dataB;
  logic                 busy;
  logic                 done;
  logic                 div_by_zero;
  logic [2*WIDTH-1:0]   dataOut;

  modport master (
    output start, Signal, dataA, dataB,
    input  busy, done, div_by_zero, dataOut
  );

  modport slave (
    input  start, Signal, dataA, dataB,
    output busy, done, div_by_zero, dataOut
  );
endinterface

// File: rtl/divu_seq.sv
// Unsigned restoring divider, one quotient bit per clock; result {remainder, quotient} with done WIDTH edges after accept.
// No backpressure: start is sampled only in IDLE, and the caller stalls on busy.
module divu_seq #(
  parameter int         WIDTH = 32,
  parameter logic [3:0] DIVU  = 4'b1100
) (
  input  logic      clk,
  input  logic      reset_n,
  divu_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;

  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_d;
  logic [WIDTH-1:0]     r_rem;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_data_out;
  logic                 r_dbz;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_ge;
  logic                 w_busy;
  logic                 w_done;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_rem_nx;
  logic [WIDTH-1:0]     w_q_nx;

  assign w_accept = bus.start && (bus.Signal == DIVU);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // R < D always holds, so the shifted remainder is below 2*D and the
  // (WIDTH+1)-bit difference never wraps: its MSB is a clean borrow flag.
  assign w_rem_sh = {r_rem, r_q[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_d};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_q_nx   = {r_q[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nx = (bus.dataB == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RUN:  w_busy = 1'b1;
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Result registers hold across RUN; only a finished or divide-by-zero request reloads them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q        <= '0;
      r_d        <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_data_out <= '0;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_q   <= bus.dataA;
            r_d   <= bus.dataB;
            r_rem <= '0;
            r_cnt <= '0;
            if (bus.dataB == '0) begin
              r_data_out <= {bus.dataA, {WIDTH{1'b1}}};
              r_dbz      <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_q   <= w_q_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_data_out <= {w_rem_nx, w_q_nx};
            r_dbz      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.dataOut     = r_data_out;

endmodule

// File: tb/tb_divu_seq.sv
// Bench for divu_seq: scenario tasks with a scoreboard queue of expected {remainder, quotient} results.
module tb_divu_seq;

  localparam int         W     = 32;
  localparam logic [3:0] DIVU  = 4'b1100;
  localparam logic [3:0] MULTU = 4'b1010;
  // Edges counted from the accepting edge to the first sample showing done.
  localparam int         LAT   = 32;

  typedef struct {
    logic [2*W-1:0] dout;
    logic           dbz;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  divu_seq_if #(.WIDTH(W)) bus ();

  divu_seq #(.WIDTH(W), .DIVU(DIVU)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.dout = {a, {W{1'b1}}};
      e.dbz  = 1'b1;
    end else begin
      e.dout = {a % b, a / b};
      e.dbz  = 1'b0;
    end
    return e;
  endfunction

  // Drive one request from an IDLE cycle and wait (bounded) for done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] obs, output logic obs_dbz, output int edges);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.Signal = DIVU;
    bus.dataA  = a;
    bus.dataB  = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.dataA  = $urandom;
    bus.dataB  = $urandom;
    edges = 0;
    while (bus.done !== 1'b1 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    obs     = bus.dataOut;
    obs_dbz = bus.div_by_zero;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.Signal = 4'h0;
    bus.dataA  = '0;
    bus.dataB  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b, required 0/0", bus.busy, bus.done);
    end
    checks++;
    if (bus.dataOut !== '0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: dataOut=%h dbz=%b, required 0/0", bus.dataOut, bus.div_by_zero);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [2*W-1:0] obs;
    logic           obs_dbz;
    int             edges;
    exp_t           e;
    sb_q.push_back(model(32'd100, 32'd7));
    run_op(32'd100, 32'd7, obs, obs_dbz, edges);
    e = sb_q.pop_front();
    checks++;
    if (edges !== LAT) begin
      errors++;
      $display("FAIL basic_latency: done after %0d edges, required %0d", edges, LAT);
    end
    checks++;
    if (obs !== {32'd2, 32'd14} || obs !== e.dout || obs_dbz !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got %h dbz=%b, required %h dbz=0", obs, obs_dbz, {32'd2, 32'd14});
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b busy=%b one cycle later, required 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0]   ta[3];
    logic [W-1:0]   tb[3];
    logic [2*W-1:0] want[3];
    logic [2*W-1:0] obs;
    logic           obs_dbz;
    int             edges;
    exp_t           e;
    ta[0] = 32'hFFFFFFFF; tb[0] = 32'd1;        want[0] = {32'd0, 32'hFFFFFFFF};
    ta[1] = 32'd5;        tb[1] = 32'd9;        want[1] = {32'd5, 32'd0};
    ta[2] = 32'h80000000; tb[2] = 32'h80000000; want[2] = {32'd0, 32'd1};
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(model(ta[i], tb[i]));
      run_op(ta[i], tb[i], obs, obs_dbz, edges);
      e = sb_q.pop_front();
      checks++;
      if (edges !== LAT || obs !== want[i] || obs !== e.dout || obs_dbz !== 1'b0) begin
        errors++;
        $display("FAIL corner_%0d: got %h dbz=%b edges=%0d, required %h dbz=0 edges=%0d",
                 i, obs, obs_dbz, edges, want[i], LAT);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [2*W-1:0] obs;
    logic           obs_dbz;
    int             edges;
    exp_t           e;
    sb_q.push_back(model(32'h1234, 32'd0));
    run_op(32'h1234, 32'd0, obs, obs_dbz, edges);
    e = sb_q.pop_front();
    checks++;
    if (edges !== 0) begin
      errors++;
      $display("FAIL dbz_latency: done after %0d edges, required 0", edges);
    end
    checks++;
    if (obs !== {32'h1234, 32'hFFFFFFFF} || obs !== e.dout || obs_dbz !== 1'b1) begin
      errors++;
      $display("FAIL dbz_result: got %h dbz=%b, required %h dbz=1", obs, obs_dbz, {32'h1234, 32'hFFFFFFFF});
    end
    // A following normal request must leave the old result visible while it runs.
    sb_q.push_back(model(32'd10, 32'd3));
    @(negedge clk);
    bus.start = 1'b1; bus.Signal = DIVU; bus.dataA = 32'd10; bus.dataB = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.dataOut !== {32'h1234, 32'hFFFFFFFF} || bus.div_by_zero !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL dbz_hold: dataOut=%h dbz=%b busy=%b in RUN, required %h dbz=1 busy=1",
               bus.dataOut, bus.div_by_zero, bus.busy, {32'h1234, 32'hFFFFFFFF});
    end
    edges = 5;
    while (bus.done !== 1'b1 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    e = sb_q.pop_front();
    checks++;
    if (edges !== LAT || bus.dataOut !== e.dout || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL dbz_followup: got %h dbz=%b edges=%0d, required %h dbz=0 edges=%0d",
               bus.dataOut, bus.div_by_zero, edges, e.dout, LAT);
    end
  endtask

  task automatic test_restart_ignored();
    int   edges;
    int   busy_drops;
    exp_t e;
    sb_q.push_back(model(32'd1000, 32'd3));
    @(negedge clk);
    bus.start = 1'b1; bus.Signal = DIVU; bus.dataA = 32'd1000; bus.dataB = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    edges = 0;
    busy_drops = 0;
    while (bus.done !== 1'b1 && edges < 100) begin
      if (bus.busy !== 1'b1) busy_drops++;
      if (edges == 10) begin
        bus.start = 1'b1; bus.dataA = 32'd77; bus.dataB = 32'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    e = sb_q.pop_front();
    checks++;
    if (busy_drops != 0) begin
      errors++;
      $display("FAIL restart_busy: busy low in %0d RUN cycles, required 0", busy_drops);
    end
    checks++;
    if (edges !== LAT || bus.dataOut !== e.dout || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL restart_result: got %h edges=%0d, required %h edges=%0d",
               bus.dataOut, edges, e.dout, LAT);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL restart_no_second: busy=%b done=%b after result, required 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_async_reset();
    int dones;
    sb_q.push_back(model(32'hDEADBEEF, 32'h1357));
    @(negedge clk);
    bus.start = 1'b1; bus.Signal = DIVU; bus.dataA = 32'hDEADBEEF; bus.dataB = 32'h1357;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (16) @(negedge clk);
    #2;
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dataOut !== '0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b dataOut=%h dbz=%b, required all 0",
               bus.busy, bus.done, bus.dataOut, bus.div_by_zero);
    end
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL async_no_done: activity in %0d cycles after reset, required 0", dones);
    end
  endtask

  task automatic test_wrong_signal();
    int busy_cnt;
    int done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.Signal = MULTU; bus.dataA = 32'd50; bus.dataB = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    checks++;
    if (busy_cnt != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL wrong_signal: busy %0d cycles, done %0d cycles, required 0/0", busy_cnt, done_cnt);
    end
  endtask

  task automatic test_random();
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] obs;
    logic           obs_dbz;
    int             edges;
    exp_t           e;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 255);
      else                           b = $urandom;
      if (b == '0) b = 32'd1;
      if (n % 7 == 0) a = a >> $urandom_range(0, 31);
      sb_q.push_back(model(a, b));
      run_op(a, b, obs, obs_dbz, edges);
      e = sb_q.pop_front();
      checks++;
      if (edges !== LAT || obs !== e.dout || obs_dbz !== e.dbz) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h got %h dbz=%b edges=%0d, required %h dbz=%b edges=%0d",
                 n, a, b, obs, obs_dbz, edges, e.dout, e.dbz, LAT);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_restart_ignored();
    test_async_reset();
    test_wrong_signal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
